// File: rtl/pipe_control_unit.sv
// Control path for a classic 5-stage pipeline: decodes the ID opcode into
// per-stage control bundles, carries them ID/EX -> EX/MEM -> MEM/WB and detects load-use hazards.
module pipe_control_unit #(
  parameter int ALUOP_W   = 4,
  parameter int RADDR_W   = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         id_op,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               flush,
  output logic               stall,
  output logic [ALUOP_W-1:0] ex_aluOp,
  output logic               ex_aluSrc,
  output logic               ex_regDst,
  output logic               ex_isJump,
  output logic               ex_isNotConditional,
  output logic               ex_isEq,
  output logic               mem_memRead,
  output logic               mem_memWrite,
  output logic               wb_regWrite,
  output logic               wb_fromAlu
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               is_jump;
    logic               is_not_cond;
    logic               is_eq;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic from_alu;
  } wb_ctrl_t;

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;
  logic      op_jump;
  logic      accept;

  // vld_pipe[1] = ID/EX, [2] = EX/MEM, [3] = MEM/WB
  logic [STAGES:1]    vld_pipe;
  ex_ctrl_t           ex_q;
  mem_ctrl_t          ex_mem_q;
  wb_ctrl_t           ex_wb_q;
  logic [RADDR_W-1:0] ex_rt;
  mem_ctrl_t          mem_mem_q;
  wb_ctrl_t           mem_wb_q;
  wb_ctrl_t           wb_q;

  // ---------------- decode ----------------
  always_comb begin
    op_jump = (id_op[5:3] == 3'd0) && (id_op[2:0] >= 3'd2) && (id_op[2:0] <= 3'd5);

    dec_ex = '0;
    if (id_op[5])              dec_ex.alu_op[3:0] = 4'd0;
    else if (op_jump)          dec_ex.alu_op[3:0] = 4'd1;
    else if (id_op == 6'd0)    dec_ex.alu_op[3:0] = 4'd2;
    else                       dec_ex.alu_op[3:0] = id_op[3:0];
    dec_ex.alu_src     = id_op[5] | id_op[3];
    dec_ex.reg_dst     = (id_op == 6'd0);
    dec_ex.is_jump     = op_jump;
    dec_ex.is_not_cond = ~id_op[2];
    dec_ex.is_eq       = ~id_op[0];

    dec_mem.mem_read  = (id_op[5:3] == 3'd4);
    dec_mem.mem_write = (id_op[5:3] == 3'd5);

    dec_wb.reg_write = ~((id_op[5:3] == 3'd5) | op_jump);
    dec_wb.from_alu  = ~id_op[5];
  end

  // ---------------- load-use hazard ----------------
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      // register 0 is hard-wired, so a load targeting it never creates a dependency
      assign stall = id_valid & vld_pipe[1] & ex_mem_q.mem_read & (ex_rt != '0)
                   & ((ex_rt == id_rs) | (ex_rt == id_rt));
    end else begin : g_no_hazard
      assign stall = 1'b0;
    end
  endgenerate

  // flush wins over stall: both load a bubble, stall still reported to fetch
  assign accept = id_valid & ~stall & ~flush;

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      ex_q      <= '0;
      ex_mem_q  <= '0;
      ex_wb_q   <= '0;
      ex_rt     <= '0;
      mem_mem_q <= '0;
      mem_wb_q  <= '0;
      wb_q      <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      ex_q      <= accept ? dec_ex  : '0;
      ex_mem_q  <= accept ? dec_mem : '0;
      ex_wb_q   <= accept ? dec_wb  : '0;
      ex_rt     <= accept ? id_rt   : '0;
      mem_mem_q <= vld_pipe[1] ? ex_mem_q : '0;
      mem_wb_q  <= vld_pipe[1] ? ex_wb_q  : '0;
      wb_q      <= vld_pipe[2] ? mem_wb_q : '0;
    end
  end

  // bubbles carry all-zero fields, so outputs read 0 whenever a stage is invalid
  assign ex_aluOp            = ex_q.alu_op;
  assign ex_aluSrc           = ex_q.alu_src;
  assign ex_regDst           = ex_q.reg_dst;
  assign ex_isJump           = ex_q.is_jump;
  assign ex_isNotConditional = ex_q.is_not_cond;
  assign ex_isEq             = ex_q.is_eq;
  assign mem_memRead         = mem_mem_q.mem_read;
  assign mem_memWrite        = mem_mem_q.mem_write;
  assign wb_regWrite         = wb_q.reg_write;
  assign wb_fromAlu          = wb_q.from_alu;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Table-driven bench for pipe_control_unit; a second instance with HAZARD_EN=0
// shares the stimulus to show the hazard unit can be disabled.
module tb_pipe_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] id_op;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       flush;

  logic       stall, stall_nh;
  logic [3:0] aluop, aluop_nh;
  logic       src, dst, jmp, notc, eq, mr, mw, rw, fa;
  logic       src_nh, dst_nh, jmp_nh, notc_nh, eq_nh, mr_nh, mw_nh, rw_nh, fa_nh;

  always #5 clk = ~clk;

  pipe_control_unit #(.ALUOP_W(4), .RADDR_W(5), .HAZARD_EN(1)) dut (
    .clk(clk), .reset(reset), .id_op(id_op), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall), .ex_aluOp(aluop), .ex_aluSrc(src), .ex_regDst(dst),
    .ex_isJump(jmp), .ex_isNotConditional(notc), .ex_isEq(eq), .mem_memRead(mr),
    .mem_memWrite(mw), .wb_regWrite(rw), .wb_fromAlu(fa));

  pipe_control_unit #(.ALUOP_W(4), .RADDR_W(5), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .reset(reset), .id_op(id_op), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall_nh), .ex_aluOp(aluop_nh), .ex_aluSrc(src_nh), .ex_regDst(dst_nh),
    .ex_isJump(jmp_nh), .ex_isNotConditional(notc_nh), .ex_isEq(eq_nh), .mem_memRead(mr_nh),
    .mem_memWrite(mw_nh), .wb_regWrite(rw_nh), .wb_fromAlu(fa_nh));

  wire [8:0] ex_bus    = {aluop, src, dst, jmp, notc, eq};
  wire [8:0] ex_bus_nh = {aluop_nh, src_nh, dst_nh, jmp_nh, notc_nh, eq_nh};
  wire [1:0] mem_bus   = {mr, mw};
  wire [1:0] wb_bus    = {rw, fa};

  // expected decode: {aluOp[3:0], aluSrc, regDst, isJump, isNotCond, isEq, memRead, memWrite, regWrite, fromAlu}
  localparam logic [12:0] D_BUB  = 13'd0;
  localparam logic [12:0] D_R    = {4'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [12:0] D_LW   = {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [12:0] D_SW   = {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [12:0] D_BEQ  = {4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [12:0] D_BNE  = {4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [12:0] D_J    = {4'd1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [12:0] D_ADDI = {4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [12:0] D_ORI  = {4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    logic [5:0]  op;
    logic        vld;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fl;
    logic        exp_stall;
    logic [12:0] exp_ex;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    id_op = op; id_valid = v; id_rs = rs; id_rt = rt; flush = fl;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ex"}, {7'd0, ex_bus}, 16'd0);
    chk({name, "_mem"}, {14'd0, mem_bus}, 16'd0);
    chk({name, "_wb"}, {14'd0, wb_bus}, 16'd0);
    chk({name, "_stall"}, {15'd0, stall}, 16'd0);
  endtask

  vec_t vecs[25];
  logic [12:0] prev1, prev2;

  initial begin
    // op, vld, rs, rt, flush, stall (before edge), EX bundle (after edge)
    vecs[0]  = '{6'h00, 1, 5'd1, 5'd2,  0, 0, D_R};
    vecs[1]  = '{6'h00, 0, 5'd0, 5'd0,  0, 0, D_BUB};
    vecs[2]  = '{6'h00, 0, 5'd0, 5'd0,  0, 0, D_BUB};
    vecs[3]  = '{6'h23, 1, 5'd1, 5'd8,  0, 0, D_LW};
    vecs[4]  = '{6'h00, 1, 5'd8, 5'd3,  0, 1, D_BUB};   // load-use on rs
    vecs[5]  = '{6'h00, 1, 5'd8, 5'd3,  0, 0, D_R};     // re-presented
    vecs[6]  = '{6'h2B, 1, 5'd2, 5'd4,  0, 0, D_SW};
    vecs[7]  = '{6'h04, 1, 5'd4, 5'd5,  0, 0, D_BEQ};
    vecs[8]  = '{6'h05, 1, 5'd4, 5'd5,  0, 0, D_BNE};
    vecs[9]  = '{6'h02, 1, 5'd0, 5'd0,  0, 0, D_J};
    vecs[10] = '{6'h08, 1, 5'd0, 5'd9,  0, 0, D_ADDI};
    vecs[11] = '{6'h0D, 1, 5'd9, 5'd10, 0, 0, D_ORI};
    vecs[12] = '{6'h23, 1, 5'd1, 5'd0,  0, 0, D_LW};    // load into r0
    vecs[13] = '{6'h00, 1, 5'd0, 5'd0,  0, 0, D_R};     // r0 never stalls
    vecs[14] = '{6'h23, 1, 5'd1, 5'd7,  0, 0, D_LW};
    vecs[15] = '{6'h00, 1, 5'd3, 5'd7,  0, 1, D_BUB};   // load-use on rt
    vecs[16] = '{6'h00, 1, 5'd3, 5'd7,  0, 0, D_R};
    vecs[17] = '{6'h23, 1, 5'd1, 5'd6,  0, 0, D_LW};
    vecs[18] = '{6'h00, 1, 5'd6, 5'd1,  1, 1, D_BUB};   // flush with stall
    vecs[19] = '{6'h00, 1, 5'd6, 5'd1,  0, 0, D_R};
    vecs[20] = '{6'h23, 1, 5'd1, 5'd5,  1, 0, D_BUB};   // flush kills valid
    vecs[21] = '{6'h23, 1, 5'd1, 5'd5,  0, 0, D_LW};
    vecs[22] = '{6'h00, 0, 5'd5, 5'd5,  0, 0, D_BUB};   // invalid ID never stalls
    vecs[23] = '{6'h00, 0, 5'd0, 5'd0,  0, 0, D_BUB};
    vecs[24] = '{6'h00, 0, 5'd0, 5'd0,  0, 0, D_BUB};

    drive(6'h00, 0, 5'd0, 5'd0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    prev1 = D_BUB;
    prev2 = D_BUB;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].vld, vecs[i].rs, vecs[i].rt, vecs[i].fl);
      #1;
      chk($sformatf("stall_%0d", i), {15'd0, stall}, {15'd0, vecs[i].exp_stall});
      chk($sformatf("nh_stall_%0d", i), {15'd0, stall_nh}, 16'd0);
      @(posedge clk);
      #1;
      chk($sformatf("ex_%0d", i), {7'd0, ex_bus}, {7'd0, vecs[i].exp_ex[12:4]});
      chk($sformatf("mem_%0d", i), {14'd0, mem_bus}, {14'd0, prev1[3:2]});
      chk($sformatf("wb_%0d", i), {14'd0, wb_bus}, {14'd0, prev2[1:0]});
      prev2 = prev1;
      prev1 = vecs[i].exp_ex;
    end

    // load followed by dependent R-type: stalls only with the hazard unit enabled
    @(negedge clk);
    drive(6'h23, 1, 5'd1, 5'd8, 0);
    @(negedge clk);
    drive(6'h00, 1, 5'd8, 5'd3, 0);
    #1;
    chk("lu_stall_en", {15'd0, stall}, 16'd1);
    chk("lu_stall_dis", {15'd0, stall_nh}, 16'd0);
    @(posedge clk);
    #1;
    chk("lu_ex_en", {7'd0, ex_bus}, 16'd0);
    chk("lu_ex_dis", {7'd0, ex_bus_nh}, {7'd0, D_R[12:4]});
    chk("lu_mem_en", {14'd0, mem_bus}, {14'd0, D_LW[3:2]});

    // three instructions in flight, then an asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(6'h00, 1, 5'd2, 5'd3, 0);
    end
    @(posedge clk);
    #1;
    chk("inflight_wb", {14'd0, wb_bus}, 16'b11);
    chk("inflight_ex", {7'd0, ex_bus}, {7'd0, D_R[12:4]});
    #2;
    drive(6'h00, 0, 5'd0, 5'd0, 0);
    reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("post_reset_wb_%0d", i), {14'd0, wb_bus}, 16'd0);
    end

    // first instruction after reset shows up on EX one cycle later
    @(negedge clk);
    drive(6'h2B, 1, 5'd1, 5'd2, 0);
    @(posedge clk);
    #1 chk("after_reset_ex", {7'd0, ex_bus}, {7'd0, D_SW[12:4]});
    @(negedge clk);
    drive(6'h00, 0, 5'd0, 5'd0, 0);
    @(posedge clk);
    #1 chk("after_reset_mem", {14'd0, mem_bus}, {14'd0, D_SW[3:2]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
